// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - datapath/display-side signal bundle for the scan driver
interface seg7_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic                    enable;
   logic                    load;
   logic [4*N_DIGITS-1:0]   value_in;
   logic [N_DIGITS-1:0]     dp_in;
   logic [N_DIGITS-1:0]     blank_in;
   logic [7:0]              seg_out;
   logic [N_DIGITS-1:0]     digit_out;
   logic                    pending;
   logic                    frame_done;

   modport master (
      output enable, load, value_in, dp_in, blank_in,
      input  seg_out, digit_out, pending, frame_done
   );

   modport slave (
      input  enable, load, value_in, dp_in, blank_in,
      output seg_out, digit_out, pending, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit 7-segment scan driver with frame-synchronous double buffering
module seg7_scan_driver #(
   parameter int N_DIGITS       = 4,
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_driver_if.slave bus
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [7:0]          SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{DIG_ACTIVE_LOW}};

   logic [CNT_W-1:0]      presc;
   logic [IDX_W-1:0]      idx;
   logic [4*N_DIGITS-1:0] act_val;
   logic [N_DIGITS-1:0]   act_dp;
   logic [N_DIGITS-1:0]   act_blank;
   logic [4*N_DIGITS-1:0] sh_val;
   logic [N_DIGITS-1:0]   sh_dp;
   logic [N_DIGITS-1:0]   sh_blank;
   logic                  pending_r;
   logic                  frame_done_r;
   logic [7:0]            seg_r;
   logic [N_DIGITS-1:0]   dig_r;

   logic                  tick;
   logic                  wrap;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [N_DIGITS-1:0]   sel_onehot;
   logic [7:0]            seg_nxt;
   logic [N_DIGITS-1:0]   dig_nxt;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      tick = bus.enable && (presc == LAST_CNT);
      wrap = tick && (idx == LAST_IDX);
   end

   // Loop mux keeps the digit select in range for non-power-of-two N_DIGITS.
   always_comb begin
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b1;
      sel_onehot = '0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_nib       = act_val[4*k +: 4];
            cur_dp        = act_dp[k];
            cur_blank     = act_blank[k];
            sel_onehot[k] = 1'b1;
         end
      end
   end

   // Blanking first, pin polarity last.
   always_comb begin
      seg_nxt = 8'h00;
      dig_nxt = '0;
      if (bus.enable && !cur_blank) begin
         seg_nxt = {cur_dp, hex_to_seg(cur_nib)};
         dig_nxt = sel_onehot;
      end
      seg_nxt = seg_nxt ^ {8{SEG_ACTIVE_LOW}};
      dig_nxt = dig_nxt ^ {N_DIGITS{DIG_ACTIVE_LOW}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (!bus.enable) begin
         presc <= '0;
         idx   <= '0;
      end else if (tick) begin
         presc <= '0;
         idx   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end else begin
         presc <= presc + CNT_W'(1);
      end
   end

   // A load coinciding with the wrap tick lands in shadow after active took the old shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_val   <= '0;
         act_dp    <= '0;
         act_blank <= '1;
         sh_val    <= '0;
         sh_dp     <= '0;
         sh_blank  <= '1;
         pending_r <= 1'b0;
      end else if (!bus.enable) begin
         if (bus.load) begin
            act_val   <= bus.value_in;
            act_dp    <= bus.dp_in;
            act_blank <= bus.blank_in;
            sh_val    <= bus.value_in;
            sh_dp     <= bus.dp_in;
            sh_blank  <= bus.blank_in;
            pending_r <= 1'b0;
         end
      end else begin
         if (wrap && pending_r) begin
            act_val   <= sh_val;
            act_dp    <= sh_dp;
            act_blank <= sh_blank;
         end
         if (bus.load) begin
            sh_val    <= bus.value_in;
            sh_dp     <= bus.dp_in;
            sh_blank  <= bus.blank_in;
            pending_r <= 1'b1;
         end else if (wrap) begin
            pending_r <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r        <= SEG_OFF;
         dig_r        <= DIG_OFF;
         frame_done_r <= 1'b0;
      end else begin
         seg_r        <= seg_nxt;
         dig_r        <= dig_nxt;
         frame_done_r <= wrap;
      end
   end

   assign bus.seg_out    = seg_r;
   assign bus.digit_out  = dig_r;
   assign bus.pending    = pending_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized and directed bench for seg7_scan_driver with behavioural model
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;

   logic clk = 1'b0;
   logic rst_n;

   seg7_scan_driver_if #(.N_DIGITS(ND)) bus ();

   seg7_scan_driver #(
      .N_DIGITS(ND),
      .SCAN_DIV(SD),
      .SEG_ACTIVE_LOW(1'b1),
      .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   logic [6:0] dec_tab [16];
   int         m_cnt;
   int         m_val [ND];
   int         m_sval [ND];
   logic [3:0] m_dp, m_bl, m_sdp, m_sbl;
   logic       m_pend;
   logic [7:0] exp_seg;
   logic [3:0] exp_dig;
   logic       exp_fd;
   logic       exp_pend;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_cnt = 0;
      for (int k = 0; k < ND; k++) begin
         m_val[k]  = 0;
         m_sval[k] = 0;
      end
      m_dp = '0; m_sdp = '0;
      m_bl = '1; m_sbl = '1;
      m_pend = 1'b0;
      exp_seg = 8'hFF; exp_dig = 4'hF; exp_fd = 1'b0; exp_pend = 1'b0;
   endtask

   // Expected outputs after the coming edge, from scan position = enabled cycles elapsed.
   task automatic model_cycle();
      int  d;
      bit  tick, wrap;
      if (bus.enable) begin
         d    = (m_cnt / SD) % ND;
         tick = (m_cnt % SD) == SD - 1;
         wrap = tick && (d == ND - 1);
         if (!m_bl[d]) begin
            exp_seg = ~{m_dp[d], dec_tab[m_val[d]]};
            exp_dig = ~(4'b0001 << d);
         end else begin
            exp_seg = 8'hFF;
            exp_dig = 4'hF;
         end
         exp_fd = wrap;
         if (wrap && m_pend) begin
            for (int k = 0; k < ND; k++) m_val[k] = m_sval[k];
            m_dp = m_sdp;
            m_bl = m_sbl;
         end
         if (bus.load) begin
            for (int k = 0; k < ND; k++) m_sval[k] = int'(bus.value_in[4*k +: 4]);
            m_sdp  = bus.dp_in;
            m_sbl  = bus.blank_in;
            m_pend = 1'b1;
         end else if (wrap) begin
            m_pend = 1'b0;
         end
         m_cnt++;
      end else begin
         exp_seg = 8'hFF;
         exp_dig = 4'hF;
         exp_fd  = 1'b0;
         m_cnt   = 0;
         if (bus.load) begin
            for (int k = 0; k < ND; k++) begin
               m_sval[k] = int'(bus.value_in[4*k +: 4]);
               m_val[k]  = m_sval[k];
            end
            m_sdp = bus.dp_in; m_dp = bus.dp_in;
            m_sbl = bus.blank_in; m_bl = bus.blank_in;
            m_pend = 1'b0;
         end
      end
      exp_pend = m_pend;
   endtask

   task automatic compare_all();
      chk("seg_out", 32'(bus.seg_out), 32'(exp_seg));
      chk("digit_out", 32'(bus.digit_out), 32'(exp_dig));
      chk("pending", 32'(bus.pending), 32'(exp_pend));
      chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
   endtask

   task automatic step();
      model_cycle();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_wrap();
      int n = 0;
      do begin
         step();
         n++;
      end while (!exp_fd && n < 64);
      if (!exp_fd) begin
         n_total++;
         $display("FAIL wrap_timeout: got no wrap within %0d cycles", n);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
      bus.value_in = v;
      bus.dp_in    = dp;
      bus.blank_in = bl;
      bus.load     = 1'b1;
      step();
      bus.load     = 1'b0;
   endtask

   task automatic lit(input string name, input logic [7:0] seg, input logic [3:0] dig);
      chk({name, "_seg"}, 32'(bus.seg_out), 32'(seg));
      chk({name, "_dig"}, 32'(bus.digit_out), 32'(dig));
   endtask

   initial begin
      int fd_count, first_fd, n;
      dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      rst_n = 1'b0;
      bus.enable = 1'b0; bus.load = 1'b0;
      bus.value_in = '0; bus.dp_in = '0; bus.blank_in = '0;
      model_reset();
      repeat (3) @(negedge clk);
      lit("reset", 8'hFF, 4'hF);
      chk("reset_pending", 32'(bus.pending), 32'd0);
      chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
      rst_n = 1'b1;

      // Enabled with everything blanked: dark display, frame pulse every 16 cycles.
      bus.enable = 1'b1;
      fd_count = 0; first_fd = 0;
      for (int i = 1; i <= 32; i++) begin
         step();
         if (bus.frame_done) begin
            fd_count++;
            if (first_fd == 0) first_fd = i;
         end
         if (bus.seg_out !== 8'hFF || bus.digit_out !== 4'hF)
            chk("dark_scan", {bus.seg_out, 4'h0, bus.digit_out}, 32'hFF0F);
      end
      chk("frame_done_count", 32'(fd_count), 32'd2);
      chk("frame_done_first", 32'(first_fd), 32'd16);

      do_load(16'h3A90, 4'b0010, 4'b0000);
      chk("load_pending", 32'(bus.pending), 32'd1);
      run_until_wrap();
      chk("applied_pending", 32'(bus.pending), 32'd0);
      step();     lit("d0_3A90", 8'hC0, 4'hE);
      steps(4);   lit("d1_3A90", 8'h10, 4'hD);
      steps(4);   lit("d2_3A90", 8'h88, 4'hB);
      steps(4);   lit("d3_3A90", 8'hB0, 4'h7);

      run_until_wrap();
      do_load(16'h1111, 4'b0000, 4'b0000);
      step();
      do_load(16'h2222, 4'b0000, 4'b0000);
      run_until_wrap();
      step();     lit("last_load_wins", 8'hA4, 4'hE);

      // Load on the wrap-tick cycle itself.
      do_load(16'h3333, 4'b0000, 4'b0000);
      n = 0;
      while ((m_cnt % 16) != 15 && n < 20) begin
         step();
         n++;
      end
      do_load(16'h4444, 4'b0000, 4'b0000);
      chk("wrap_load_pending", 32'(bus.pending), 32'd1);
      step();     lit("wrap_load_old", 8'hB0, 4'hE);
      chk("wrap_load_pending_held", 32'(bus.pending), 32'd1);
      run_until_wrap();
      chk("wrap_load_cleared", 32'(bus.pending), 32'd0);
      step();     lit("wrap_load_new", 8'h99, 4'hE);

      bus.enable = 1'b0;
      step();     lit("disabled", 8'hFF, 4'hF);
      do_load(16'h00F0, 4'b0000, 4'b0100);
      chk("disabled_load_pending", 32'(bus.pending), 32'd0);
      bus.enable = 1'b1;
      step();     lit("reenable_d0", 8'hC0, 4'hE);
      steps(4);   lit("reenable_d1", 8'h8E, 4'hD);
      steps(4);   lit("reenable_d2_blank", 8'hFF, 4'hF);

      // Async reset while digit 2 is lit.
      do_load(16'h00F0, 4'b0000, 4'b0000);
      run_until_wrap();
      n = 0;
      while ((m_cnt % 16) != 9 && n < 20) begin
         step();
         n++;
      end
      lit("pre_reset_d2", 8'hC0, 4'hB);
      rst_n = 1'b0;
      #1;
      lit("async_reset", 8'hFF, 4'hF);
      chk("async_reset_pending", 32'(bus.pending), 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();     lit("post_reset_blank", 8'hFF, 4'hF);
      steps(15);

      for (int i = 0; i < 2000; i++) begin
         bus.enable   = ($urandom_range(0, 19) != 0);
         bus.load     = ($urandom_range(0, 7) == 0);
         bus.value_in = 16'($urandom);
         bus.dp_in    = 4'($urandom);
         bus.blank_in = 4'($urandom) & 4'($urandom);
         step();
      end
      bus.load = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
